tx_arbiter: RTL
===============

# tx_arbiter

Two-requester scheduler that shares the single UART transmitter of the serial device between an echo path and a local key path. The echo path carries bytes completed by the receiver. The key path carries the zero-extended 4-bit switch value captured on the debounced send pulse. The block buffers one byte per requester, grants the transmitter round-robin, and issues the transmitter's one-cycle start pulse. Because the transmitter has no busy output, the block enforces frame spacing with its own counter.

## Interface
- CLKS_PER_BIT, default 5208: clock cycles per UART bit, matching the transmitter's baud divisor.
- FRAME_BITS, default 10: bits per frame (start + 8 data + stop).
- GUARD_CYCLES, default 16: idle cycles appended after each frame.
- Derived: F = CLKS_PER_BIT*FRAME_BITS + GUARD_CYCLES. The counter width is clog2(F).
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- echo_valid  in  1  one-cycle pulse: echo_data is valid (receiver `finished`).
- echo_data  in  8  byte to echo.
- key_valid  in  1  one-cycle pulse: key_data is valid (send-button start pulse).
- key_data  in  8  byte from the key path.
- tx_start  out  1  one-cycle pulse to the transmitter's `iniciar_envio`.
- tx_data  out  8  byte to the transmitter; stable from tx_start until the next launch.
- busy  out  1  high while a frame is in flight (state != IDLE).
- grant_key  out  1  source of the last launch: 0 = echo, 1 = key.
- echo_drop  out  1  one-cycle pulse: an echo byte was discarded because its buffer was full.
- key_drop  out  1  one-cycle pulse: a key byte was discarded because its buffer was full.

## Operation
- Each requester has a one-entry buffer: an 8-bit register plus a pending flag.
- Buffer capture rules:
  - valid with pending=0: the byte is latched and pending is set.
  - valid with pending=1 and no grant to that requester in the same cycle: the byte is discarded, the drop output pulses on the next cycle, and the buffer is left unchanged.
  - valid in the same cycle that requester is granted: the old byte launches, the new byte is latched, and pending stays 1. This is not a drop.
- State machine states: IDLE, WAIT.
- IDLE, no pending buffer: stay in IDLE.
- IDLE, at least one pending buffer, on the next edge:
  - Choose the winner. A single pending requester wins. If both are pending, the requester not equal to grant_key wins (round-robin).
  - Set tx_start=1 and tx_data to the winner's byte.
  - Update grant_key and clear the winner's pending flag.
  - Load the counter with F-1 and move to WAIT.
- WAIT: tx_start=0. Decrement the counter each cycle. When the counter reaches 0, move to IDLE on the next edge.
- A request arriving during WAIT is buffered, not dropped, provided that requester's buffer is empty.
- Reset values:
  - state=IDLE, counter=0, both pending=0, both byte registers=0.
  - tx_start=0, tx_data=0x00, busy=0.
  - grant_key=1, so echo wins the first tie.
  - echo_drop=0, key_drop=0.
- Reset mid-frame: aborts the spacing and discards both buffers. The transmitter is not signalled; a frame already in progress on its line completes on its own.

## Timing
- Valid pulse at cycle 0: pending visible at cycle 1, tx_start high at cycle 2 if idle. Idle latency is 2 cycles.
- tx_start is exactly 1 cycle wide. busy rises in the same cycle as tx_start.
- The counter is F-1 during the tx_start cycle and reaches 0 F-1 cycles later. busy falls F cycles after tx_start rises.
- Back-to-back launches are spaced exactly F+1 cycles apart (tx_start to tx_start).
- A drop pulse appears 1 cycle after the offending valid.
- Reset asserted at cycle n: all outputs are at reset values from cycle n+1.

## Test plan
Use CLKS_PER_BIT=4, FRAME_BITS=10, GUARD_CYCLES=2, so F=42.
- Single echo: echo_valid with 0x41 at cycle 0 -> tx_start at cycle 2 with tx_data=0x41, grant_key=0; busy high cycles 2..43, low at cycle 44.
- Simultaneous requests after reset: echo 0x55 and key 0x03 both at cycle 0 -> echo launches at cycle 2 and key at cycle 45 with tx_data=0x03, grant_key=1. No drops.
- Round-robin under saturation: both requesters re-requested immediately after each grant for 6 launches -> grant_key sequence 0,1,0,1,0,1; launches spaced 43 cycles.
- Overflow: key 0x01 at cycle 0, then key 0x02 and key 0x05 during WAIT -> 0x02 is buffered; 0x05 is dropped with key_drop pulsing 1 cycle after it; launches are 0x01 then 0x02.
- Grant-cycle refill: key 0x07 buffered, and key_valid with 0x09 in the IDLE grant cycle -> 0x07 launches, 0x09 launches 43 cycles later, key_drop never pulses.
- Reset mid-WAIT: reset at cycle 20 after a launch at cycle 2, with echo pending -> from cycle 21, busy=0 and tx_data=0x00; no further tx_start until a new valid arrives.

Source files
------------

// File: rtl/tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter between an echo path and a key path.
// Buffers one byte per requester and enforces frame spacing with a local down-counter.
module tx_arbiter #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned FRAME_BITS   = 10,
  parameter int unsigned GUARD_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       echo_valid,
  input  logic [7:0] echo_data,
  input  logic       key_valid,
  input  logic [7:0] key_data,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       grant_key,
  output logic       echo_drop,
  output logic       key_drop
);

  localparam int unsigned FrameCycles = CLKS_PER_BIT * FRAME_BITS + GUARD_CYCLES;
  localparam int unsigned CntW        = (FrameCycles > 1) ? $clog2(FrameCycles) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(FrameCycles - 1);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            echo_pend_q, echo_pend_d;
  logic            key_pend_q, key_pend_d;
  logic [7:0]      echo_buf_q, echo_buf_d;
  logic [7:0]      key_buf_q, key_buf_d;
  logic            tx_start_q, tx_start_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            grant_key_q, grant_key_d;
  logic            echo_drop_q, echo_drop_d;
  logic            key_drop_q, key_drop_d;
  logic            launch, win_key, grant_echo_now, grant_key_now;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    echo_pend_d    = echo_pend_q;
    key_pend_d     = key_pend_q;
    echo_buf_d     = echo_buf_q;
    key_buf_d      = key_buf_q;
    tx_start_d     = 1'b0;
    tx_data_d      = tx_data_q;
    grant_key_d    = grant_key_q;
    echo_drop_d    = 1'b0;
    key_drop_d     = 1'b0;
    launch         = 1'b0;
    win_key        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (echo_pend_q || key_pend_q) begin
          launch = 1'b1;
          // On a tie the requester that did not win last time goes next.
          win_key     = key_pend_q & (~echo_pend_q | ~grant_key_q);
          tx_start_d  = 1'b1;
          tx_data_d   = win_key ? key_buf_q : echo_buf_q;
          grant_key_d = win_key;
          cnt_d       = CntLoad;
          state_d     = StWait;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    grant_echo_now = launch & ~win_key;
    grant_key_now  = launch & win_key;

    if (grant_echo_now) echo_pend_d = 1'b0;
    if (grant_key_now)  key_pend_d  = 1'b0;

    // A request landing in its own grant cycle refills the freed slot.
    if (echo_valid) begin
      if (!echo_pend_q || grant_echo_now) begin
        echo_buf_d  = echo_data;
        echo_pend_d = 1'b1;
      end else begin
        echo_drop_d = 1'b1;
      end
    end

    if (key_valid) begin
      if (!key_pend_q || grant_key_now) begin
        key_buf_d  = key_data;
        key_pend_d = 1'b1;
      end else begin
        key_drop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      echo_pend_q <= 1'b0;
      key_pend_q  <= 1'b0;
      echo_buf_q  <= 8'h00;
      key_buf_q   <= 8'h00;
      tx_start_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      grant_key_q <= 1'b1;
      echo_drop_q <= 1'b0;
      key_drop_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      echo_pend_q <= echo_pend_d;
      key_pend_q  <= key_pend_d;
      echo_buf_q  <= echo_buf_d;
      key_buf_q   <= key_buf_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      grant_key_q <= grant_key_d;
      echo_drop_q <= echo_drop_d;
      key_drop_q  <= key_drop_d;
    end
  end

  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign busy      = (state_q != StIdle);
  assign grant_key = grant_key_q;
  assign echo_drop = echo_drop_q;
  assign key_drop  = key_drop_q;

endmodule
